// File: rtl/dll_delay_ctrl.sv
// Digital DLL delay-code controller: binary-search (SAR) acquisition followed
// by +/-1 tracking with lock detection on alternating phase-detector results.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  run enable; low returns to IDLE with code held
//   start               pulse that (re)starts SAR acquisition
//   pd_valid, pd_lead   phase-detector strobe and direction (1 = add delay)
//   code                binary delay code, 0..N_CELLS
//   t_code, tb_code     thermometer select (code > i) and its complement
//   busy, locked        acquisition/tracking active, lock indication
//   sat_hi, sat_lo      one-cycle pulses when a tracking step is clipped
module dll_delay_ctrl #(
    parameter int unsigned CODE_W   = 5,
    parameter int unsigned SETTLE   = 4,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      start,
    input  logic                      pd_valid,
    input  logic                      pd_lead,
    output logic [CODE_W-1:0]         code,
    output logic [(2**CODE_W)-2:0]    t_code,
    output logic [(2**CODE_W)-2:0]    tb_code,
    output logic                      busy,
    output logic                      locked,
    output logic                      sat_hi,
    output logic                      sat_lo
);

    localparam int unsigned N_CELLS = (1 << CODE_W) - 1;
    localparam int unsigned PTR_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int unsigned SET_W   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int unsigned LCK_W   = (LOCK_CNT > 0) ? $clog2(LOCK_CNT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SAR, S_TRACK} state_t;

    state_t               r_state, w_state_nxt;
    logic [CODE_W-1:0]    r_code, w_code_nxt, w_code_sar;
    logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;
    logic [SET_W-1:0]     r_settle, w_settle_nxt;
    logic [LCK_W-1:0]     r_lock_cnt, w_lock_cnt_nxt;
    logic                 r_locked, w_locked_nxt;
    logic                 r_have_dir, w_have_dir_nxt;
    logic                 r_last_dir, w_last_dir_nxt;
    logic                 r_sat_hi, w_sat_hi_nxt;
    logic                 r_sat_lo, w_sat_lo_nxt;
    logic                 r_busy;
    logic [N_CELLS-1:0]   r_t_code, r_tb_code, w_t_nxt;
    logic                 w_sample;

    // A phase sample counts only once the settle window has expired.
    assign w_sample = pd_valid && (r_settle == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic: en low beats start, start beats a pending sample
    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = S_IDLE;
        end else if (start) begin
            w_state_nxt = S_SAR;
        end else if (r_state == S_SAR && w_sample && r_ptr == PTR_W'(0)) begin
            w_state_nxt = S_TRACK;
        end
    end

    // Datapath next values (code, pointer, settle, lock, saturation)
    always_comb begin
        w_code_nxt     = r_code;
        w_ptr_nxt      = r_ptr;
        w_settle_nxt   = (r_settle != '0) ? r_settle - SET_W'(1) : '0;
        w_lock_cnt_nxt = r_lock_cnt;
        w_locked_nxt   = r_locked;
        w_have_dir_nxt = r_have_dir;
        w_last_dir_nxt = r_last_dir;
        w_sat_hi_nxt   = 1'b0;
        w_sat_lo_nxt   = 1'b0;

        // SAR trial: resolve bit at pointer, tentatively set the next bit down
        w_code_sar          = r_code;
        w_code_sar[r_ptr]   = pd_lead;
        if (r_ptr != PTR_W'(0)) w_code_sar[r_ptr - PTR_W'(1)] = 1'b1;

        if (!en) begin
            w_settle_nxt   = '0;
            w_lock_cnt_nxt = '0;
            w_locked_nxt   = 1'b0;
            w_have_dir_nxt = 1'b0;
        end else if (start) begin
            w_code_nxt     = CODE_W'(1) << (CODE_W - 1);
            w_ptr_nxt      = PTR_W'(CODE_W - 1);
            w_settle_nxt   = SET_W'(SETTLE);
            w_lock_cnt_nxt = '0;
            w_locked_nxt   = 1'b0;
            w_have_dir_nxt = 1'b0;
        end else if (r_state == S_SAR && w_sample) begin
            w_code_nxt = w_code_sar;
            if (r_ptr != PTR_W'(0)) w_ptr_nxt = r_ptr - PTR_W'(1);
            // Resolving bit 0 high leaves the code as is: no new settle window
            if (w_code_sar != r_code) w_settle_nxt = SET_W'(SETTLE);
        end else if (r_state == S_TRACK && w_sample) begin
            if (pd_lead) begin
                if (r_code == CODE_W'(N_CELLS)) begin
                    w_sat_hi_nxt = 1'b1;
                end else begin
                    w_code_nxt   = r_code + CODE_W'(1);
                    w_settle_nxt = SET_W'(SETTLE);
                end
            end else begin
                if (r_code == '0) begin
                    w_sat_lo_nxt = 1'b1;
                end else begin
                    w_code_nxt   = r_code - CODE_W'(1);
                    w_settle_nxt = SET_W'(SETTLE);
                end
            end
            // Lock tracks consecutive direction alternations
            w_last_dir_nxt = pd_lead;
            if (!r_have_dir) begin
                w_have_dir_nxt = 1'b1;
            end else if (pd_lead != r_last_dir) begin
                w_lock_cnt_nxt = (r_lock_cnt == LCK_W'(LOCK_CNT)) ? r_lock_cnt
                                                                  : r_lock_cnt + LCK_W'(1);
                w_locked_nxt   = (w_lock_cnt_nxt == LCK_W'(LOCK_CNT));
            end else begin
                w_lock_cnt_nxt = '0;
                w_locked_nxt   = 1'b0;
            end
        end

        for (int i = 0; i < int'(N_CELLS); i++) begin
            w_t_nxt[i] = (w_code_nxt > CODE_W'(i));
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code     <= '0;
            r_ptr      <= '0;
            r_settle   <= '0;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
            r_have_dir <= 1'b0;
            r_last_dir <= 1'b0;
            r_sat_hi   <= 1'b0;
            r_sat_lo   <= 1'b0;
            r_busy     <= 1'b0;
            r_t_code   <= '0;
            r_tb_code  <= '1;
        end else begin
            r_code     <= w_code_nxt;
            r_ptr      <= w_ptr_nxt;
            r_settle   <= w_settle_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_locked   <= w_locked_nxt;
            r_have_dir <= w_have_dir_nxt;
            r_last_dir <= w_last_dir_nxt;
            r_sat_hi   <= w_sat_hi_nxt;
            r_sat_lo   <= w_sat_lo_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_t_code   <= w_t_nxt;
            r_tb_code  <= ~w_t_nxt;
        end
    end

    assign code    = r_code;
    assign t_code  = r_t_code;
    assign tb_code = r_tb_code;
    assign busy    = r_busy;
    assign locked  = r_locked;
    assign sat_hi  = r_sat_hi;
    assign sat_lo  = r_sat_lo;

endmodule

// File: tb/tb_dll_delay_ctrl.sv
// Testbench for dll_delay_ctrl: directed scenarios plus random traffic, with
// a per-cycle scoreboard fed by a behavioural model of the controller.
module tb_dll_delay_ctrl;

    localparam int CODE_W   = 5;
    localparam int SETTLE   = 4;
    localparam int LOCK_CNT = 4;
    localparam int N        = (1 << CODE_W) - 1;
    localparam int IDLE = 0, SAR = 1, TRACK = 2;

    logic              clk, rst_n, en, start, pd_valid, pd_lead;
    logic [CODE_W-1:0] code;
    logic [N-1:0]      t_code, tb_code;
    logic              busy, locked, sat_hi, sat_lo;

    dll_delay_ctrl #(.CODE_W(CODE_W), .SETTLE(SETTLE), .LOCK_CNT(LOCK_CNT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start),
        .pd_valid(pd_valid), .pd_lead(pd_lead),
        .code(code), .t_code(t_code), .tb_code(tb_code),
        .busy(busy), .locked(locked), .sat_hi(sat_hi), .sat_lo(sat_lo)
    );

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [N-1:0]      t;
        logic [N-1:0]      tb;
        logic              busy;
        logic              locked;
        logic              sat_hi;
        logic              sat_lo;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model state
    int m_state, m_code, m_bit, m_age;
    bit m_locked, m_sat_hi, m_sat_lo;
    bit hist[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [N-1:0] therm(input int c);
        logic [63:0] v;
        v = (64'd1 << c) - 64'd1;
        return v[N-1:0];
    endfunction

    function automatic int trail_alt();
        int cnt = 0;
        for (int i = hist.size() - 1; i > 0; i--) begin
            if (hist[i] != hist[i-1]) cnt++;
            else break;
        end
        return cnt;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.code   = CODE_W'(m_code);
        o.t      = therm(m_code);
        o.tb     = ~therm(m_code);
        o.busy   = (m_state != IDLE);
        o.locked = m_locked;
        o.sat_hi = m_sat_hi;
        o.sat_lo = m_sat_lo;
        return o;
    endfunction

    task automatic model_reset();
        m_state = IDLE; m_code = 0; m_bit = 0; m_age = 1000;
        m_locked = 0; m_sat_hi = 0; m_sat_lo = 0;
        hist.delete();
    endtask

    // One clock of the reference behaviour for the given inputs
    task automatic model_step(input bit e, input bit s, input bit pv, input bit ld);
        int nc;
        bit acc;
        acc = pv && (m_age >= SETTLE);
        m_sat_hi = 0;
        m_sat_lo = 0;
        if (!e) begin
            m_state = IDLE; m_locked = 0; hist.delete(); m_age++;
        end else if (s) begin
            m_state = SAR; m_code = 1 << (CODE_W - 1); m_bit = CODE_W - 1;
            m_age = 0; m_locked = 0; hist.delete();
        end else if (m_state == SAR && acc) begin
            nc = ld ? m_code : m_code - (1 << m_bit);
            if (m_bit > 0) nc += 1 << (m_bit - 1);
            else           m_state = TRACK;
            m_bit--;
            m_age  = (nc != m_code) ? 0 : m_age + 1;
            m_code = nc;
        end else if (m_state == TRACK && acc) begin
            if (ld && m_code == N)       begin m_sat_hi = 1; m_age++; end
            else if (!ld && m_code == 0) begin m_sat_lo = 1; m_age++; end
            else begin m_code = ld ? m_code + 1 : m_code - 1; m_age = 0; end
            hist.push_back(ld);
            if (hist.size() > 16) void'(hist.pop_front());
            m_locked = (trail_alt() >= LOCK_CNT);
        end else begin
            m_age++;
        end
    endtask

    task automatic chk(input string nm, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the expected post-edge outputs
    task automatic drive(input bit e, input bit s, input bit pv, input bit ld);
        @(negedge clk);
        en = e; start = s; pd_valid = pv; pd_lead = ld;
        model_step(e, s, pv, ld);
        exp_q.push_back(model_obs());
    endtask

    task automatic settle_then_sample(input bit ld);
        repeat (SETTLE) drive(1, 0, 0, 0);
        drive(1, 0, 1, ld);
        @(posedge clk); #3;
    endtask

    task automatic do_start();
        drive(1, 1, 0, 0);
        @(posedge clk); #3;
    endtask

    initial begin
        int exp_codes[$];
        int held, tgt;
        bit e, s, pv, ld;

        rst_n = 1'b0; en = 0; start = 0; pd_valid = 0; pd_lead = 0;
        model_reset();

        // Scoreboard monitor, one expected entry per driven cycle
        fork
            begin : monitor
                obs_t ex, got;
                forever begin
                    @(posedge clk); #2;
                    if (exp_q.size() != 0) begin
                        ex  = exp_q.pop_front();
                        got = {code, t_code, tb_code, busy, locked, sat_hi, sat_lo};
                        n_checks++;
                        if (got !== ex) begin
                            n_fail++;
                            $display("FAIL scoreboard @%0t: code got %0d exp %0d, t_code got %h exp %h, tb_code got %h exp %h, busy/locked/sat_hi/sat_lo got %b%b%b%b exp %b%b%b%b",
                                $time, got.code, ex.code, got.t, ex.t, got.tb, ex.tb,
                                got.busy, got.locked, got.sat_hi, got.sat_lo,
                                ex.busy, ex.locked, ex.sat_hi, ex.sat_lo);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #3;
        chk("reset_code", code, 0);
        chk("reset_tb_code", tb_code, 64'h7FFFFFFF);
        @(negedge clk) rst_n = 1'b1;

        // No activity without start
        repeat (6) drive(1, 0, 1'(bit'($urandom_range(0, 1))), bit'($urandom_range(0, 1)));
        drive(0, 1, 0, 0);
        @(posedge clk); #3;
        chk("idle_busy", busy, 0);
        chk("idle_code", code, 0);

        // All-lead acquisition
        do_start();
        chk("sar_start_code", code, 16);
        exp_codes = '{24, 28, 30, 31, 31};
        foreach (exp_codes[i]) begin
            settle_then_sample(1);
            chk("sar_all_lead_code", code, exp_codes[i]);
        end
        chk("sar_all_lead_busy", busy, 1);

        // Upper saturation
        settle_then_sample(1);
        chk("sat_hi_pulse", sat_hi, 1);
        chk("sat_hi_code", code, 31);
        drive(1, 0, 0, 0);
        @(posedge clk); #3;
        chk("sat_hi_one_cycle", sat_hi, 0);
        settle_then_sample(0);
        settle_then_sample(1);
        settle_then_sample(0);
        settle_then_sample(1);
        chk("lock_at_top", locked, 1);
        settle_then_sample(1);
        chk("sat_hi_clears_lock", locked, 0);
        chk("sat_hi_again", sat_hi, 1);
        chk("sat_hi_code_held", code, 31);

        // All-late acquisition then lower saturation
        do_start();
        exp_codes = '{8, 4, 2, 1, 0};
        foreach (exp_codes[i]) begin
            settle_then_sample(0);
            chk("sar_all_late_code", code, exp_codes[i]);
        end
        settle_then_sample(0);
        chk("sat_lo_pulse", sat_lo, 1);
        chk("sat_lo_code", code, 0);

        // Acquire target 19 then track to lock
        do_start();
        chk("sar19_start", code, 16);
        exp_codes = '{24, 20, 18, 19, 18};
        foreach (exp_codes[i]) begin
            settle_then_sample(m_code < 19);
            chk("sar19_code", code, exp_codes[i]);
        end
        for (int k = 1; k <= 5; k++) begin
            settle_then_sample(m_code < 19);
            if (k == 4) chk("track19_not_yet_locked", locked, 0);
        end
        chk("track19_locked", locked, 1);
        chk("track19_code", code, 19);

        // Settle filter: early strobe ignored, strobe at SETTLE+1 accepted
        drive(1, 0, 0, 0);
        drive(1, 0, 1, 0);
        @(posedge clk); #3;
        chk("settle_early_ignored", code, 19);
        repeat (SETTLE - 2) drive(1, 0, 0, 0);
        drive(1, 0, 1, 0);
        @(posedge clk); #3;
        chk("settle_accept", code, 18);
        chk("settle_lock_kept", locked, 1);

        // Restart mid-SAR with a same-cycle strobe
        do_start();
        settle_then_sample(1);
        settle_then_sample(0);
        chk("mid_sar_code", code, 20);
        repeat (SETTLE) drive(1, 0, 0, 0);
        drive(1, 1, 1, 1);
        @(posedge clk); #3;
        chk("restart_code", code, 16);
        chk("restart_locked", locked, 0);

        // Abort during TRACK
        for (int k = 0; k < 7; k++) settle_then_sample(bit'($urandom_range(0, 1)));
        held = m_code;
        drive(0, 1, 1, 1);
        @(posedge clk); #3;
        chk("abort_busy", busy, 0);
        chk("abort_code_held", code, held);

        // Asynchronous reset mid-cycle while busy
        do_start();
        settle_then_sample(1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_code", code, 0);
        chk("async_rst_t_code", t_code, 0);
        chk("async_rst_tb_code", tb_code, 64'h7FFFFFFF);
        chk("async_rst_locked", locked, 0);
        chk("async_rst_busy", busy, 0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        // Random traffic steered towards a wandering target
        tgt = $urandom_range(0, N);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) tgt = $urandom_range(0, N);
            e  = ($urandom_range(0, 149) != 0);
            s  = ($urandom_range(0, 79) == 0);
            pv = ($urandom_range(0, 2) == 0);
            ld = ($urandom_range(0, 4) == 0) ? bit'($urandom_range(0, 1)) : (m_code < tgt);
            drive(e, s, pv, ld);
        end
        @(posedge clk); #3;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dll_delay_ctrl.md
DLL_DELAY_CTRL -- requirements
Module: dll_delay_ctrl

Interface
REQ-001 Parameter CODE_W, default 5: delay-code width; the controlled chain has N_CELLS = 2^CODE_W - 1 delay cells.
REQ-002 Parameter SETTLE, default 4: clock cycles waited after any code change before a phase sample is accepted.
REQ-003 Parameter LOCK_CNT, default 4: consecutive direction alternations required to declare lock.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  high = run acquisition/tracking; low = return to IDLE, code held.
REQ-007 start  input  1  one-cycle pulse; begins (or restarts) binary-search acquisition.
REQ-008 pd_valid  input  1  one-cycle strobe, phase-detector result valid.
REQ-009 pd_lead  input  1  1 = feedback early, increase delay; 0 = feedback late, decrease delay; sampled only with pd_valid.
REQ-010 code  output  CODE_W  current binary delay code, 0..N_CELLS.
REQ-011 t_code  output  N_CELLS  thermometer select to delay cells: t_code[i] = (code > i).
REQ-012 tb_code  output  N_CELLS  bitwise complement of t_code, same cycle.
REQ-013 busy  output  1  high in SAR or TRACK.
REQ-014 locked  output  1  lock indication.
REQ-015 sat_hi / sat_lo  output  1 each  one-cycle pulse when a TRACK step is clipped at N_CELLS / 0.

Function
REQ-016 States: IDLE, SAR, TRACK; t_code, tb_code, code all registered, no combinational path from inputs to outputs.
REQ-017 IDLE: code held, busy=0, locked=0; start with en=1 -> SAR, code = 1<<(CODE_W-1), bit pointer = MSB, settle counter loaded.
REQ-018 Settle: after every code change, pd_valid ignored for SETTLE cycles; first pd_valid after that is one "sample".
REQ-019 SAR sample at pointer b: pd_lead=1 keeps bit b, pd_lead=0 clears bit b; if b>0, bit b-1 set in the same update and pointer decrements.
REQ-020 SAR sample at b=0: bit 0 resolved, state -> TRACK next cycle; exactly CODE_W samples per acquisition.
REQ-021 TRACK sample: pd_lead=1 -> code+1, pd_lead=0 -> code-1; code never wraps; increment at N_CELLS holds code and pulses sat_hi; decrement at 0 holds and pulses sat_lo.
REQ-022 Code update appears on outputs the cycle after the accepted sample (latency 1); a clipped step does not restart settle.
REQ-023 Lock counter (TRACK only): sample direction differing from previous sample direction increments it (saturating at LOCK_CNT); same direction clears it and clears locked; first TRACK sample only records direction.
REQ-024 locked=1 from the cycle after the counter reaches LOCK_CNT; cleared on SAR entry, IDLE, or same-direction sample.
REQ-025 start while in SAR or TRACK restarts SAR per REQ-017; start has priority over a same-cycle pd_valid.
REQ-026 en=0 in any state -> IDLE next cycle, code held, pending sample discarded; en=0 has priority over start.

Reset
REQ-027 While rst_n=0: state IDLE, code=0, t_code=all 0, tb_code=all 1, busy=0, locked=0, sat_hi=sat_lo=0, settle and lock counters 0; applies immediately, independent of clk.
REQ-028 After rst_n release, no activity until start with en=1.

Verification
REQ-029 Reset: rst_n=0 asserted mid-cycle -> code=0, t_code=31'h0, tb_code=31'h7FFFFFFF, locked=0 without a clock edge.
REQ-030 SAR all-lead: en=1, start, pd_lead=1 on every sample -> code 16,24,28,30,31; TRACK entered after 5th sample.
REQ-031 SAR to target: pd_lead=(code<19) -> codes 16,24,20,18,19,18; then TRACK toggles 19/18, locked=1 after 4th alternation.
REQ-032 Settle filter: pd_valid pulsed 2 cycles after a code change -> ignored, code unchanged; pulse at cycle SETTLE+1 -> accepted.
REQ-033 Saturation: TRACK at code=31, pd_lead=1 -> code stays 31, sat_hi pulses one cycle, locked cleared; same at 0 with sat_lo.
REQ-034 Restart/abort: start mid-SAR -> code=16, locked=0; en=0 during TRACK -> IDLE next cycle, code held, busy=0.
